// File: rtl/iob_eth_tx_loader.sv
// -----------------------------------------------------------------------------
// iob_eth_tx_loader
//
// Bus-master feeder for the Ethernet core's CPU-side register/buffer port.
// Takes a byte stream from an upstream producer and, for each frame:
//   1. polls the core status register until TX ready (bit 0) is set,
//   2. writes each payload byte into the TX buffer window at DATA_BASE+idx,
//   3. programs TX_NBYTES with max(idx, MIN_BYTES),
//   4. writes 1 to the SEND register.
// Frames longer than MAX_BYTES are truncated: the remainder is drained and
// discarded, the frame is not sent and the sticky err_ovf flag is raised.
//
// Optional build macro: IOB_ETH_TX_LOADER_PAD_EN
//   When defined, short frames are zero-padded in the TX buffer up to
//   MIN_BYTES before TX_NBYTES is programmed.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     upstream byte handshake; s_data byte, s_last end mark
//   eth_valid/ready     core bus request / response (one outstanding access)
//   eth_wstrb           1 = write, 0 = read
//   eth_addr/wdata      core address / write data, held until eth_ready
//   eth_rdata           core read data, valid while eth_ready = 1
//   busy                high whenever the loader is not IDLE
//   frame_cnt           frames sent, wraps at 65535
//   err_ovf             sticky oversize-frame flag, cleared only by rst
// -----------------------------------------------------------------------------
module iob_eth_tx_loader #(
    parameter int ETH_ADDR_W     = 12,
    parameter int STATUS_ADDR    = 0,
    parameter int SEND_ADDR      = 1,
    parameter int TX_NBYTES_ADDR = 3,
    parameter int DATA_BASE      = 2048,
    parameter int MAX_BYTES      = 1500,
    parameter int MIN_BYTES      = 46,
    parameter int POLL_GAP       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  eth_valid,
    output logic                  eth_wstrb,
    output logic [ETH_ADDR_W-1:0] eth_addr,
    output logic [31:0]           eth_wdata,
    input  logic [31:0]           eth_rdata,
    input  logic                  eth_ready,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic                  err_ovf
);

    localparam int IDX_W = 11;
    localparam int GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_LOAD,
`ifdef IOB_ETH_TX_LOADER_PAD_EN
        S_PAD,
`endif
        S_NBYTES,
        S_SEND,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   last_q, last_d;      // final byte's write is in flight
    logic                   ovf_q, ovf_d;        // MAX_BYTES-th byte's write is in flight
    logic                   valid_d, wstrb_d, err_ovf_d;
    logic [ETH_ADDR_W-1:0]  addr_d;
    logic [31:0]            wdata_d;
    logic [15:0]            frame_cnt_d;

    logic [ETH_ADDR_W-1:0]  data_addr;
    logic [IDX_W-1:0]       nbytes;
    logic                   unused_rdata;

    assign data_addr    = ETH_ADDR_W'(DATA_BASE) + ETH_ADDR_W'(idx_q);
    assign nbytes       = (idx_q < IDX_W'(MIN_BYTES)) ? IDX_W'(MIN_BYTES) : idx_q;
    assign unused_rdata = ^eth_rdata[31:1];

    // Gated by rst so no byte is taken in the reset cycle itself.
    assign s_ready = !rst && (((state_q == S_LOAD) && !eth_valid) || (state_q == S_DRAIN));
    assign busy    = (state_q != S_IDLE);

    // Every state that drives the bus follows the same pattern: issue when
    // eth_valid is low, hold everything while waiting, drop eth_valid on the
    // eth_ready cycle. Leaving a state always happens on that cycle, so each
    // state is entered with the bus idle.
    always_comb begin
        // NOTE: every next-state variable is defaulted to its current value
        // first so no path through the case leaves one unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        last_d      = last_q;
        ovf_d       = ovf_q;
        valid_d     = eth_valid;
        wstrb_d     = eth_wstrb;
        addr_d      = eth_addr;
        wdata_d     = eth_wdata;
        frame_cnt_d = frame_cnt;
        err_ovf_d   = err_ovf;

        case (state_q)
            S_IDLE: begin
                if (s_valid) begin
                    state_d = S_POLL;
                    gap_d   = '0;
                end
            end

            S_POLL: begin
                if (eth_valid) begin
                    if (eth_ready) begin
                        valid_d = 1'b0;
                        if (eth_rdata[0]) state_d = S_LOAD;
                        else              gap_d   = GAP_W'(POLL_GAP);
                    end
                end else if (gap_q <= GAP_W'(1)) begin
                    // Last idle cycle of the gap: the request lands right after it.
                    gap_d   = '0;
                    valid_d = 1'b1;
                    wstrb_d = 1'b0;
                    addr_d  = ETH_ADDR_W'(STATUS_ADDR);
                    wdata_d = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            S_LOAD: begin
                if (eth_valid) begin
                    if (eth_ready) begin
                        valid_d = 1'b0;
                        if (last_q) begin
                            last_d  = 1'b0;
`ifdef IOB_ETH_TX_LOADER_PAD_EN
                            state_d = S_PAD;
`else
                            state_d = S_NBYTES;
`endif
                        end else if (ovf_q) begin
                            ovf_d   = 1'b0;
                            state_d = S_DRAIN;
                        end
                    end
                end else if (s_valid && s_ready) begin
                    valid_d = 1'b1;
                    wstrb_d = 1'b1;
                    addr_d  = data_addr;
                    wdata_d = {24'd0, s_data};
                    idx_d   = idx_q + IDX_W'(1);
                    if (s_last) begin
                        last_d = 1'b1;
                    end else if (idx_q == IDX_W'(MAX_BYTES - 1)) begin
                        ovf_d     = 1'b1;
                        err_ovf_d = 1'b1;
                    end
                end
            end

`ifdef IOB_ETH_TX_LOADER_PAD_EN
            S_PAD: begin
                if (eth_valid) begin
                    if (eth_ready) valid_d = 1'b0;
                end else if (idx_q < IDX_W'(MIN_BYTES)) begin
                    valid_d = 1'b1;
                    wstrb_d = 1'b1;
                    addr_d  = data_addr;
                    wdata_d = '0;
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    state_d = S_NBYTES;
                end
            end
`endif

            S_NBYTES: begin
                if (eth_valid) begin
                    if (eth_ready) begin
                        valid_d = 1'b0;
                        state_d = S_SEND;
                    end
                end else begin
                    valid_d = 1'b1;
                    wstrb_d = 1'b1;
                    addr_d  = ETH_ADDR_W'(TX_NBYTES_ADDR);
                    wdata_d = 32'(nbytes);
                end
            end

            S_SEND: begin
                if (eth_valid) begin
                    if (eth_ready) begin
                        valid_d     = 1'b0;
                        frame_cnt_d = frame_cnt + 16'd1;
                        idx_d       = '0;
                        state_d     = S_IDLE;
                    end
                end else begin
                    valid_d = 1'b1;
                    wstrb_d = 1'b1;
                    addr_d  = ETH_ADDR_W'(SEND_ADDR);
                    wdata_d = 32'd1;
                end
            end

            S_DRAIN: begin
                if (s_valid && s_ready && s_last) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; rst is just the highest-priority branch.
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
            eth_valid <= 1'b0;
            eth_wstrb <= 1'b0;
            eth_addr  <= '0;
            eth_wdata <= '0;
            frame_cnt <= '0;
            err_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register updates from pre-edge values.
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            eth_valid <= valid_d;
            eth_wstrb <= wstrb_d;
            eth_addr  <= addr_d;
            eth_wdata <= wdata_d;
            frame_cnt <= frame_cnt_d;
            err_ovf   <= err_ovf_d;
        end
    end

endmodule

// File: tb/tb_iob_eth_tx_loader.sv
// -----------------------------------------------------------------------------
// tb_iob_eth_tx_loader
//
// Directed bench for iob_eth_tx_loader. A behavioural core model answers bus
// requests one cycle after eth_valid, serves status reads from a programmable
// not-ready count and compares every write against a scoreboard queue that
// the stimulus fills as frames are offered.
// -----------------------------------------------------------------------------
module tb_iob_eth_tx_loader;

    localparam int AW          = 12;
    localparam int STATUS_ADDR = 0;
    localparam int SEND_ADDR   = 1;
    localparam int NB_ADDR     = 3;
    localparam int DATA_BASE   = 2048;
    localparam int MAX_BYTES   = 1500;
    localparam int MIN_BYTES   = 46;
    localparam int POLL_GAP    = 4;
    localparam int BYTE_BOUND  = 300;
    localparam int IDLE_BOUND  = 6000;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_last;
    logic          s_ready;
    logic          eth_valid;
    logic          eth_wstrb;
    logic [AW-1:0] eth_addr;
    logic [31:0]   eth_wdata;
    logic [31:0]   eth_rdata;
    logic          eth_ready;
    logic          busy;
    logic [15:0]   frame_cnt;
    logic          err_ovf;

    int checks   = 0;
    int failures = 0;

    logic [AW+31:0] sb[$];          // expected writes: {addr, wdata}
    int             read_times[$];  // cycle of each status-read response
    int             not_ready_left = 0;
    int             status_reads   = 0;
    int             reads_at_first_write = -1;
    bit             first_write_seen = 0;
    int             sends = 0;
    int             cyc = 0;
    int             exp_frames = 0;

    iob_eth_tx_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .eth_valid (eth_valid),
        .eth_wstrb (eth_wstrb),
        .eth_addr  (eth_addr),
        .eth_wdata (eth_wdata),
        .eth_rdata (eth_rdata),
        .eth_ready (eth_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_ovf   (err_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Core model: a request seen on one falling edge is answered on the next,
    // i.e. eth_ready is high in the cycle after eth_valid first rose.
    initial begin
        bit seen = 0;
        logic [AW+31:0] exp_wr;
        eth_ready = 1'b0;
        eth_rdata = '0;
        forever begin
            @(negedge clk);
            if (eth_ready) begin
                eth_ready = 1'b0;
                eth_rdata = '0;
                seen      = 0;
            end else if (eth_valid && !rst) begin
                if (!seen) begin
                    seen = 1;
                end else begin
                    eth_ready = 1'b1;
                    if (!eth_wstrb) begin
                        check("status_read_addr", 64'(eth_addr), 64'(STATUS_ADDR));
                        status_reads++;
                        read_times.push_back(cyc);
                        if (not_ready_left > 0) begin
                            not_ready_left--;
                            eth_rdata = 32'd0;
                        end else begin
                            eth_rdata = 32'd1;
                        end
                    end else begin
                        if (eth_addr[11] && !first_write_seen) begin
                            first_write_seen     = 1;
                            reads_at_first_write = status_reads;
                        end
                        if (eth_addr == AW'(SEND_ADDR)) sends++;
                        check("write_expected", 64'(sb.size() != 0), 64'(1));
                        if (sb.size() != 0) begin
                            exp_wr = sb.pop_front();
                            check("bus_write", 64'({eth_addr, eth_wdata}), 64'(exp_wr));
                        end
                    end
                end
            end else begin
                seen = 0;
            end
        end
    end

    // Offer one byte from a falling edge until it is taken; returns on the
    // falling edge after the accepting rising edge, s_valid still high.
    task automatic push_byte(input logic [7:0] d, input logic l);
        bit acc = 0;
        int n   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc && n < BYTE_BOUND) begin
            acc = s_ready;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!acc) check("byte_accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic wait_quiet(input string tag, input bit need_idle);
        int n = 0;
        while ((sb.size() != 0 || eth_valid || eth_ready || (need_idle && busy)) && n < IDLE_BOUND) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < IDLE_BOUND), 64'(1));
    endtask

    task automatic send_frame(input int len, input logic [7:0] seed, input int stall_at,
                              input int stall_len, input bit wait_done);
        logic [7:0] b;
        int nb;
        for (int i = 0; i < len && i < MAX_BYTES; i++) begin
            b = seed + 8'(i);
            sb.push_back({AW'(DATA_BASE + i), 24'd0, b});
        end
        if (len <= MAX_BYTES) begin
`ifdef IOB_ETH_TX_LOADER_PAD_EN
            for (int i = len; i < MIN_BYTES; i++) sb.push_back({AW'(DATA_BASE + i), 32'd0});
`endif
            nb = (len < MIN_BYTES) ? MIN_BYTES : len;
            sb.push_back({AW'(NB_ADDR), 32'(nb)});
            sb.push_back({AW'(SEND_ADDR), 32'd1});
        end
        for (int i = 0; i < len; i++) begin
            if (i == stall_at) begin
                s_valid = 1'b0;
                repeat (stall_len) @(negedge clk);
            end
            push_byte(seed + 8'(i), (i == len - 1));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (wait_done) wait_quiet("frame_complete", 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_eth_valid"}, 64'(eth_valid), 64'(0));
        check({tag, "_eth_wstrb"}, 64'(eth_wstrb), 64'(0));
        check({tag, "_eth_addr"},  64'(eth_addr),  64'(0));
        check({tag, "_eth_wdata"}, 64'(eth_wdata), 64'(0));
        check({tag, "_s_ready"},   64'(s_ready),   64'(0));
        check({tag, "_busy"},      64'(busy),      64'(0));
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
        check({tag, "_err_ovf"},   64'(err_ovf),   64'(0));
    endtask

    initial begin
        logic [7:0] b;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 60-byte frame, core ready at the first poll.
        status_reads = 0; first_write_seen = 0; sends = 0;
        send_frame(60, 8'h00, -1, 0, 1);
        exp_frames++;
        check("t1_reads_before_data", 64'(reads_at_first_write), 64'(1));
        check("t1_sends", 64'(sends), 64'(1));
        check("t1_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        check("t1_busy_after_send", 64'(busy), 64'(0));

        // Three not-ready polls before TX ready.
        status_reads = 0; first_write_seen = 0; read_times.delete();
        not_ready_left = 3;
        send_frame(8, 8'h40, -1, 0, 1);
        exp_frames++;
        check("t2_status_reads", 64'(status_reads), 64'(4));
        check("t2_reads_before_data", 64'(reads_at_first_write), 64'(4));
        for (int k = 1; k < read_times.size(); k++)
            check("t2_poll_spacing", 64'(read_times[k] - read_times[k-1]), 64'(POLL_GAP + 2));
        check("t2_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // Short frame: TX_NBYTES forced to the minimum.
        send_frame(10, 8'hA0, -1, 0, 1);
        exp_frames++;
        check("t3_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        check("t3_err_ovf", 64'(err_ovf), 64'(0));

        // Oversize frame, then a normal frame.
        sends = 0;
        send_frame(1600, 8'h11, -1, 0, 1);
        check("t4_err_ovf", 64'(err_ovf), 64'(1));
        check("t4_no_send", 64'(sends), 64'(0));
        check("t4_frame_cnt_hold", 64'(frame_cnt), 64'(exp_frames));
        send_frame(64, 8'h20, -1, 0, 1);
        exp_frames++;
        check("t4_next_sends", 64'(sends), 64'(1));
        check("t4_next_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
        check("t4_err_ovf_sticky", 64'(err_ovf), 64'(1));

        // Mid-frame upstream stall, then a back-to-back frame.
        sends = 0;
        send_frame(40, 8'h55, 25, 50, 0);
        send_frame(30, 8'h77, -1, 0, 1);
        exp_frames += 2;
        check("t5_sends", 64'(sends), 64'(2));
        check("t5_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        // Reset after 20 bytes of a frame.
        for (int i = 0; i < 20; i++) begin
            b = 8'h90 + 8'(i);
            sb.push_back({AW'(DATA_BASE + i), 24'd0, b});
            push_byte(b, 1'b0);
        end
        s_valid = 1'b0;
        wait_quiet("t6_bytes_written", 0);
        check("t6_busy_mid_frame", 64'(busy), 64'(1));
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b0;
        #1;
        check("t6_s_ready_in_rst", 64'(s_ready), 64'(0));
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b0;
        check_all_zero("t6_after_rst");
        exp_frames = 0;
        status_reads = 0; first_write_seen = 0; sends = 0;
        send_frame(30, 8'hC0, -1, 0, 1);
        exp_frames++;
        check("t6_fresh_poll", 64'(reads_at_first_write), 64'(1));
        check("t6_sends", 64'(sends), 64'(1));
        check("t6_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
